// File: rtl/mdu_exec.sv
// Multiply/divide execution unit with private HI/LO registers: pipelined-latency MULT/MULTU,
// iterative restoring DIV/DIVU, MTHI/MTLO/MFHI/MFLO. Optional macro: MDU_DIV_ZERO_FAST_EN.
module mdu_exec #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned PRF_W   = 6,
    parameter int unsigned ROB_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op,
    input  logic [31:0]      issue_src_a,
    input  logic [31:0]      issue_src_b,
    input  logic [PRF_W-1:0] issue_dst,
    input  logic [ROB_W-1:0] issue_rob_id,
    output logic             issue_ready,
    output logic             wb_valid,
    output logic [PRF_W-1:0] wb_dst,
    output logic [31:0]      wb_data,
    output logic             cmpl_valid,
    output logic [ROB_W-1:0] cmpl_rob_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } mdu_op_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 2);
    localparam logic [5:0] DIV_LAST = 6'd32;

    state_t             state_q, state_d;
    mdu_op_t            op;
    logic               accept;
    logic               mul_step, mul_done, div_step, div_done;
    logic [5:0]         cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic [ROB_W-1:0]   rob_q;

    // Operand conditioning shared by multiply and divide setup
    logic               sgn_op, a_neg, b_neg, b_zero, fast_dz;
    logic [31:0]        a_mag, b_mag;
    logic [63:0]        mul_a, mul_b, prod_d, prod_q;

    // Divider state: quotient shifts in from the bottom while dividend bits shift out the top
    logic [31:0]        quo_q, rem_q, dvs_q, dva_q;
    logic               neg_quo_q, neg_rem_q, dz_q;
    logic [32:0]        div_shift, div_diff;
    logic [31:0]        div_lo, div_hi;

    assign op          = mdu_op_t'(issue_op);
    assign issue_ready = (state_q == S_IDLE);
    assign accept      = issue_valid && issue_ready && !flush;

    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg  = sgn_op & issue_src_a[31];
    assign b_neg  = sgn_op & issue_src_b[31];
    assign a_mag  = a_neg ? (32'd0 - issue_src_a) : issue_src_a;
    assign b_mag  = b_neg ? (32'd0 - issue_src_b) : issue_src_b;
    assign b_zero = (issue_src_b == '0);

    assign mul_a  = {{32{a_neg}}, issue_src_a};
    assign mul_b  = {{32{b_neg}}, issue_src_b};
    assign prod_d = mul_a * mul_b;

`ifdef MDU_DIV_ZERO_FAST_EN
    assign fast_dz = b_zero;
`else
    assign fast_dz = 1'b0;
`endif

    assign div_shift = {rem_q, quo_q[31]};
    assign div_diff  = div_shift - {1'b0, dvs_q};

    always_comb begin
        div_lo = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        div_hi = neg_rem_q ? (32'd0 - rem_q) : rem_q;
        // A zero divisor still iterates, but its result is defined independently of the datapath
        if (dz_q) begin
            div_lo = '1;
            div_hi = dva_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mul_step = 1'b0;
        mul_done = 1'b0;
        div_step = 1'b0;
        div_done = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MULT || op == OP_MULTU) begin
                            state_d = S_MUL;
                        end else if ((op == OP_DIV || op == OP_DIVU) && !fast_dz) begin
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        mul_done = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        mul_step = 1'b1;
                    end
                end
                S_DIV: begin
                    if (cnt_q == DIV_LAST) begin
                        div_done = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        div_step = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            rob_q       <= '0;
            prod_q      <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            dva_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            wb_valid    <= 1'b0;
            wb_dst      <= '0;
            wb_data     <= '0;
            cmpl_valid  <= 1'b0;
            cmpl_rob_id <= '0;
        end else begin
            wb_valid   <= 1'b0;
            cmpl_valid <= 1'b0;
            if (accept) begin
                cnt_q <= '0;
                rob_q <= issue_rob_id;
                unique case (op)
                    OP_MULT, OP_MULTU: begin
                        prod_q <= prod_d;
                    end
                    OP_DIV, OP_DIVU: begin
                        quo_q     <= a_mag;
                        rem_q     <= '0;
                        dvs_q     <= b_mag;
                        dva_q     <= issue_src_a;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dz_q      <= b_zero;
                        if (fast_dz) begin
                            lo_q        <= '1;
                            hi_q        <= issue_src_a;
                            cmpl_valid  <= 1'b1;
                            cmpl_rob_id <= issue_rob_id;
                        end
                    end
                    OP_MTHI: begin
                        hi_q        <= issue_src_a;
                        cmpl_valid  <= 1'b1;
                        cmpl_rob_id <= issue_rob_id;
                    end
                    OP_MTLO: begin
                        lo_q        <= issue_src_a;
                        cmpl_valid  <= 1'b1;
                        cmpl_rob_id <= issue_rob_id;
                    end
                    OP_MFHI, OP_MFLO: begin
                        wb_valid    <= 1'b1;
                        wb_dst      <= issue_dst;
                        wb_data     <= (op == OP_MFHI) ? hi_q : lo_q;
                        cmpl_valid  <= 1'b1;
                        cmpl_rob_id <= issue_rob_id;
                    end
                endcase
            end else if (mul_done) begin
                {hi_q, lo_q} <= prod_q;
                cmpl_valid   <= 1'b1;
                cmpl_rob_id  <= rob_q;
            end else if (div_done) begin
                hi_q        <= div_hi;
                lo_q        <= div_lo;
                cmpl_valid  <= 1'b1;
                cmpl_rob_id <= rob_q;
            end else if (div_step) begin
                if (!div_diff[32]) begin
                    rem_q <= div_diff[31:0];
                    quo_q <= {quo_q[30:0], 1'b1};
                end else begin
                    rem_q <= div_shift[31:0];
                    quo_q <= {quo_q[30:0], 1'b0};
                end
                cnt_q <= cnt_q + 6'd1;
            end else if (mul_step) begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

endmodule
